// File: rtl/updn_pkg.sv
// rtl/updn_pkg.sv - shared constants and types for the up/down modulo counter
package updn_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Decision taken at an edge once reset has been ruled out
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC,
    ACT_WRAP_LO,
    ACT_WRAP_HI,
    ACT_CLAMP,
    ACT_SAT
  } updn_act_e;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/updn_next.sv
// rtl/updn_next.sv - next-state logic for updn_mod_counter
// Optional saturation input present when UPDN_SAT_EN is defined.
module updn_next
  import updn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             ud_i,
  input  logic [WIDTH-1:0] max_val_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
`ifdef UPDN_SAT_EN
  input  logic             sat_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             tc_o
);

  logic      sat_w;
  logic      at_top;
  logic      at_zero;
  logic      above_max;
  updn_act_e act;

`ifdef UPDN_SAT_EN
  assign sat_w = sat_i;
`else
  assign sat_w = 1'b0;
`endif

  assign at_top    = (count_i >= max_val_i);
  assign at_zero   = (count_i == '0);
  assign above_max = (count_i > max_val_i);

  always_comb begin
    act = ACT_HOLD;
    if (load_i) begin
      act = ACT_LOAD;
    end else if (en_i) begin
      if (ud_i == DIR_UP) begin
        if (at_top) act = sat_w ? ACT_SAT : ACT_WRAP_LO;
        else        act = ACT_INC;
      end else if (above_max) begin
        // max_val was lowered under a running count: snap down without a wrap
        act = ACT_CLAMP;
      end else if (at_zero) begin
        act = sat_w ? ACT_SAT : ACT_WRAP_HI;
      end else begin
        act = ACT_DEC;
      end
    end
  end

  always_comb begin
    count_o = count_i;
    wrap_o  = 1'b0;
    case (act)
      ACT_LOAD:    count_o = (load_val_i > max_val_i) ? max_val_i : load_val_i;
      ACT_INC:     count_o = count_i + WIDTH'(1);
      ACT_DEC:     count_o = count_i - WIDTH'(1);
      ACT_WRAP_LO: begin
        count_o = '0;
        wrap_o  = 1'b1;
      end
      ACT_WRAP_HI: begin
        count_o = max_val_i;
        wrap_o  = 1'b1;
      end
      ACT_CLAMP:   count_o = max_val_i;
      ACT_SAT:     count_o = (ud_i == DIR_UP) ? max_val_i : '0;
      default:     count_o = count_i;
    endcase
  end

  assign tc_o = (ud_i == DIR_UP) ? (count_i == max_val_i) : at_zero;

endmodule

// File: rtl/updn_mod_counter.sv
// rtl/updn_mod_counter.sv - up/down counter over 0..max_val with load and wrap pulse
// Define UPDN_SAT_EN to add the sat input (saturate instead of wrap).
module updn_mod_counter
  import updn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
`ifdef UPDN_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("updn_mod_counter: WIDTH must be within WIDTH_MIN..WIDTH_MAX");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  updn_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i    (count_q),
    .ud_i       (ud),
    .max_val_i  (max_val),
    .load_i     (load),
    .load_val_i (load_val),
    .en_i       (en),
`ifdef UPDN_SAT_EN
    .sat_i      (sat),
`endif
    .count_o    (count_d),
    .wrap_o     (wrap_d),
    .tc_o       (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
